// File: rtl/bus_mem_bridge.sv
// Valid/ready bus slave bridging one request at a time
// onto a single-port synchronous word SRAM.
module bus_mem_bridge #(
  parameter int BUS_WIDTH    = 32,
  parameter int ADDR_WIDTH   = 10,
  parameter int READ_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  raddr_valid,
  output logic                  raddr_ready,
  input  logic [BUS_WIDTH-1:0]  raddr,
  output logic                  rdata_valid,
  input  logic                  rdata_ready,
  output logic [BUS_WIDTH-1:0]  rdata,
  input  logic                  w_valid,
  output logic                  w_ready,
  input  logic [BUS_WIDTH-1:0]  waddr,
  input  logic [BUS_WIDTH-1:0]  wdata,
  output logic                  mem_en,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [BUS_WIDTH-1:0]  mem_wdata,
  input  logic [BUS_WIDTH-1:0]  mem_rdata
);

  localparam int LW = 3;

  typedef enum logic [2:0] {
    IDLE,
    WR,
    RD_REQ,
    RD_WAIT,
    RD_RESP
  } state_t;

  state_t        state_q;
  state_t        state_d;
  logic [LW-1:0] lat_q;
  logic [LW-1:0] lat_d;
  logic          acc_w;
  logic          acc_r;
  logic          cap;
  logic          idle;

  // Byte-lane and high address bits are dropped: accesses alias.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{raddr[1:0], raddr[BUS_WIDTH-1:ADDR_WIDTH+2],
                              waddr[1:0], waddr[BUS_WIDTH-1:ADDR_WIDTH+2]};

  // Readies are masked by reset so they drop asynchronously too.
  assign idle        = (state_q == IDLE);
  assign raddr_ready = rst & idle;
  assign w_ready     = rst & idle;
  assign rdata_valid = (state_q == RD_RESP);

  // Next-state, latency countdown and SRAM strobes.
  always_comb begin
    state_d = state_q;
    lat_d   = lat_q;
    acc_w   = 1'b0;
    acc_r   = 1'b0;
    cap     = 1'b0;
    mem_en  = 1'b0;
    mem_we  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (w_valid) begin
          acc_w   = 1'b1;
          state_d = WR;
        end else if (raddr_valid) begin
          acc_r   = 1'b1;
          state_d = RD_REQ;
        end
      end
      WR: begin
        mem_en  = 1'b1;
        mem_we  = 1'b1;
        state_d = IDLE;
      end
      RD_REQ: begin
        mem_en  = 1'b1;
        lat_d   = LW'(READ_LATENCY - 1);
        state_d = RD_WAIT;
      end
      RD_WAIT: begin
        if (lat_q != '0) begin
          lat_d = lat_q - 1'b1;
        end else begin
          cap     = 1'b1;
          state_d = RD_RESP;
        end
      end
      RD_RESP: begin
        if (rdata_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and latency counter registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      lat_q   <= '0;
    end else begin
      state_q <= state_d;
      lat_q   <= lat_d;
    end
  end

  // Latch request address/data and capture returned read data.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem_addr  <= '0;
      mem_wdata <= '0;
      rdata     <= '0;
    end else begin
      if (acc_w) begin
        mem_addr  <= waddr[ADDR_WIDTH+1:2];
        mem_wdata <= wdata;
      end else if (acc_r) begin
        mem_addr  <= raddr[ADDR_WIDTH+1:2];
      end
      if (cap) rdata <= mem_rdata;
    end
  end

endmodule

// File: tb/tb_bus_mem_bridge.sv
// Randomised self-checking bench for bus_mem_bridge
// against a word-level memory reference model.
module tb_bus_mem_bridge;

  localparam int BW  = 32;
  localparam int AW  = 10;
  localparam int LAT = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic          raddr_valid;
  logic          raddr_ready;
  logic [BW-1:0] raddr;
  logic          rdata_valid;
  logic          rdata_ready;
  logic [BW-1:0] rdata;
  logic          w_valid;
  logic          w_ready;
  logic [BW-1:0] waddr;
  logic [BW-1:0] wdata;
  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [BW-1:0] mem_wdata;
  logic [BW-1:0] mem_rdata;

  int total = 0;
  int bad   = 0;

  logic [BW-1:0] ref_mem [int];
  logic [BW-1:0] sram [1<<AW];
  logic [BW-1:0] pipe [LAT];

  always #5 clk = ~clk;

  bus_mem_bridge #(
    .BUS_WIDTH(BW),
    .ADDR_WIDTH(AW),
    .READ_LATENCY(LAT)
  ) u_dut (
    .clk(clk),
    .rst(rst),
    .raddr_valid(raddr_valid),
    .raddr_ready(raddr_ready),
    .raddr(raddr),
    .rdata_valid(rdata_valid),
    .rdata_ready(rdata_ready),
    .rdata(rdata),
    .w_valid(w_valid),
    .w_ready(w_ready),
    .waddr(waddr),
    .wdata(wdata),
    .mem_en(mem_en),
    .mem_we(mem_we),
    .mem_addr(mem_addr),
    .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  // SRAM macro: LAT-stage read pipeline, garbage when not reading.
  always @(posedge clk) begin
    if (mem_en && mem_we) sram[mem_addr] <= mem_wdata;
    pipe[0] <= (mem_en && !mem_we) ? sram[mem_addr] : 32'hBAD0BAD0;
    for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
  end
  assign mem_rdata = pipe[LAT-1];

  function automatic logic [BW-1:0] ref_rd(input logic [BW-1:0] a);
    int k;
    k = int'(a / 4) % (1 << AW);
    return ref_mem.exists(k) ? ref_mem[k] : '0;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input logic [BW-1:0] a, input logic [BW-1:0] d);
    int n = 0;
    while (!w_ready && n < 20) begin step(); n++; end
    total++;
    if (!w_ready) begin
      bad++;
      $display("FAIL wr_wait: w_ready=%b required 1", w_ready);
    end
    w_valid = 1'b1; waddr = a; wdata = d;
    step();
    w_valid = 1'b0;
    total++;
    if (mem_en !== 1'b1 || mem_we !== 1'b1 ||
        mem_addr !== AW'(a / 4) || mem_wdata !== d) begin
      bad++;
      $display("FAIL wr_strobe: en=%b we=%b addr=%h wd=%h required 1 1 %h %h",
               mem_en, mem_we, mem_addr, mem_wdata, AW'(a / 4), d);
    end
    ref_mem[int'(a / 4) % (1 << AW)] = d;
    step();
    total++;
    if (w_ready !== 1'b1 || mem_en !== 1'b0) begin
      bad++;
      $display("FAIL wr_turn: w_ready=%b en=%b required 1 0", w_ready, mem_en);
    end
  endtask

  task automatic do_read(input logic [BW-1:0] a, input int hold);
    int n = 0;
    logic [BW-1:0] exp;
    exp = ref_rd(a);
    rdata_ready = (hold == 0);
    while (!raddr_ready && n < 20) begin step(); n++; end
    total++;
    if (!raddr_ready) begin
      bad++;
      $display("FAIL rd_wait: raddr_ready=%b required 1", raddr_ready);
    end
    raddr_valid = 1'b1; raddr = a;
    step();
    raddr_valid = 1'b0;
    total++;
    if (mem_en !== 1'b1 || mem_we !== 1'b0 || mem_addr !== AW'(a / 4)) begin
      bad++;
      $display("FAIL rd_strobe: en=%b we=%b addr=%h required 1 0 %h",
               mem_en, mem_we, mem_addr, AW'(a / 4));
    end
    for (int c = 2; c < LAT + 2; c++) begin
      step();
      total++;
      if (rdata_valid !== 1'b0 || raddr_ready !== 1'b0 || mem_en !== 1'b0) begin
        bad++;
        $display("FAIL rd_early: cyc=%0d valid=%b rdy=%b en=%b required 0 0 0",
                 c, rdata_valid, raddr_ready, mem_en);
      end
    end
    step();
    total++;
    if (rdata_valid !== 1'b1 || rdata !== exp || raddr_ready !== 1'b0) begin
      bad++;
      $display("FAIL rd_data: valid=%b rdata=%h rdy=%b required 1 %h 0",
               rdata_valid, rdata, raddr_ready, exp);
    end
    for (int h = 1; h < hold; h++) begin
      step();
      total++;
      if (rdata_valid !== 1'b1 || rdata !== exp || raddr_ready !== 1'b0) begin
        bad++;
        $display("FAIL rd_hold: h=%0d valid=%b rdata=%h rdy=%b required 1 %h 0",
                 h, rdata_valid, rdata, raddr_ready, exp);
      end
    end
    rdata_ready = 1'b1;
    step();
    total++;
    if (rdata_valid !== 1'b0 || raddr_ready !== 1'b1 || rdata !== exp) begin
      bad++;
      $display("FAIL rd_done: valid=%b rdy=%b rdata=%h required 0 1 %h",
               rdata_valid, raddr_ready, rdata, exp);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      total++;
      if ({raddr_ready, w_ready, rdata_valid, mem_en, mem_we} !== 5'b0 ||
          rdata !== '0 || mem_addr !== '0 || mem_wdata !== '0) begin
        bad++;
        $display("FAIL reset_out: rr=%b wr=%b v=%b en=%b we=%b rd=%h a=%h wd=%h required all 0",
                 raddr_ready, w_ready, rdata_valid, mem_en, mem_we,
                 rdata, mem_addr, mem_wdata);
      end
    end
    rst = 1'b1;
    #1;
    total++;
    if (w_ready !== 1'b1 || raddr_ready !== 1'b1) begin
      bad++;
      $display("FAIL reset_rdy: w_ready=%b raddr_ready=%b required 1 1",
               w_ready, raddr_ready);
    end
    do_write(32'h10, 32'hDEADBEEF);
  endtask

  task automatic test_read_latency();
    do_read(32'h12, 0);
  endtask

  task automatic test_backpressure();
    do_read(32'h12, 5);
  endtask

  task automatic test_simultaneous();
    w_valid = 1'b1; waddr = '0; wdata = 32'h1;
    raddr_valid = 1'b1; raddr = '0;
    step();
    w_valid = 1'b0;
    total++;
    if (mem_we !== 1'b1 || mem_en !== 1'b1 || mem_addr !== '0 ||
        mem_wdata !== 32'h1 || raddr_ready !== 1'b0) begin
      bad++;
      $display("FAIL simul_wr: en=%b we=%b a=%h wd=%h rr=%b required 1 1 0 1 0",
               mem_en, mem_we, mem_addr, mem_wdata, raddr_ready);
    end
    ref_mem[0] = 32'h1;
    step();
    total++;
    if (raddr_ready !== 1'b1) begin
      bad++;
      $display("FAIL simul_rd_rdy: raddr_ready=%b required 1", raddr_ready);
    end
    do_read(32'h0, 0);
  endtask

  task automatic test_alias();
    do_write(32'h1000, 32'h55);
    do_read(32'h0, 0);
  endtask

  task automatic test_random();
    for (int i = 0; i < 24; i++) begin
      logic [BW-1:0] a;
      a = {$urandom_range(3, 0), 18'h0, 2'($urandom_range(1, 0)),
           6'($urandom_range(15, 0)), 2'($urandom)};
      if ($urandom_range(1, 0) == 1)
        do_write(a, $urandom);
      else
        do_read(a, int'($urandom_range(3, 0)));
    end
  endtask

  task automatic test_reset_mid_read();
    raddr_valid = 1'b1; raddr = 32'h10;
    step();
    raddr_valid = 1'b0;
    step();
    rst = 1'b0;
    #1;
    total++;
    if ({raddr_ready, w_ready, rdata_valid, mem_en, mem_we} !== 5'b0 ||
        rdata !== '0 || mem_addr !== '0 || mem_wdata !== '0) begin
      bad++;
      $display("FAIL mid_reset_out: rr=%b wr=%b v=%b en=%b we=%b rd=%h a=%h wd=%h required all 0",
               raddr_ready, w_ready, rdata_valid, mem_en, mem_we,
               rdata, mem_addr, mem_wdata);
    end
    w_valid = 1'b1; waddr = 32'h20; wdata = 32'hBAD;
    for (int i = 0; i < 2; i++) begin
      step();
      total++;
      if (mem_en !== 1'b0 || rdata_valid !== 1'b0) begin
        bad++;
        $display("FAIL mid_reset_hold: en=%b valid=%b required 0 0",
                 mem_en, rdata_valid);
      end
    end
    w_valid = 1'b0;
    rst = 1'b1;
    #1;
    total++;
    if (w_ready !== 1'b1 || raddr_ready !== 1'b1) begin
      bad++;
      $display("FAIL mid_reset_rdy: w_ready=%b raddr_ready=%b required 1 1",
               w_ready, raddr_ready);
    end
    for (int i = 0; i < LAT + 3; i++) begin
      step();
      total++;
      if (rdata_valid !== 1'b0) begin
        bad++;
        $display("FAIL mid_reset_drop: valid=%b required 0", rdata_valid);
      end
    end
    do_read(32'h20, 1);
  endtask

  initial begin
    for (int i = 0; i < (1 << AW); i++) sram[i] = '0;
    for (int i = 0; i < LAT; i++) pipe[i] = '0;
    rst = 1'b0;
    raddr_valid = 1'b0; raddr = '0;
    rdata_ready = 1'b1;
    w_valid = 1'b0; waddr = '0; wdata = '0;
    #1;
    test_reset();
    test_read_latency();
    test_backpressure();
    test_simultaneous();
    test_alias();
    test_random();
    test_reset_mid_read();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
